// File: rtl/ram_request_arbiter.sv
// ram_request_arbiter: serialises instruction-fetch and data requests onto one RAM port.
// Optional macro MEM_TIMEOUT_EN adds a grant watchdog with a sticky timeout_err flag.
module ram_request_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              ramREN,
    output logic              ramWEN,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              timeout_err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ram_request_arbiter: TIMEOUT must be at least 1");
    end

    state_t            state_r;
    logic              last_data_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] store_r;
    logic              ren_r;
    logic              wen_r;

    logic              dreq_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              granted_s;
    logic              access_s;
    logic              own_req_s;
    logic              expire_s;
    logic              release_s;
    logic [DATA_W-1:0] rel_word_s;

    assign dreq_s    = dREN | dWEN;
    // Data wins unless it was served last and the fetch is also waiting.
    assign grant_i_s = iREN & (~dreq_s | last_data_r);
    assign grant_d_s = dreq_s & ~(iREN & last_data_r);
    assign granted_s = (state_r == DGRANT) | (state_r == IGRANT);
    assign access_s  = (ramstate == RAM_ACCESS);
    assign own_req_s = (state_r == DGRANT) ? dreq_s : iREN;
    assign release_s = granted_s & (access_s | expire_s);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             timeout_err_r;

    assign expire_s    = granted_s & ~access_s & (cnt_r == CNT_W'(TIMEOUT - 1));
    assign rel_word_s  = access_s ? ramload : DATA_W'(32'hDEAD_BEEF);
    assign timeout_err = timeout_err_r;

    // Watchdog: counts grant cycles, restarts in IDLE, latches any expiry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r         <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (granted_s) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            timeout_err_r <= timeout_err_r | expire_s;
        end
    end
`else
    assign expire_s    = 1'b0;
    assign rel_word_s  = ramload;
    assign timeout_err = 1'b0;
`endif

    assign ramaddr  = addr_r;
    assign ramstore = store_r;
    assign ramREN   = ren_r;
    assign ramWEN   = wen_r;

    // Completion is combinational so the owner sees release in the ACCESS cycle itself.
    always_comb begin
        dwait = 1'b1;
        iwait = 1'b1;
        dload = {DATA_W{1'b0}};
        iload = {DATA_W{1'b0}};
        if (release_s && (state_r == DGRANT)) begin
            dwait = 1'b0;
            dload = rel_word_s;
        end else if (release_s) begin
            iwait = 1'b0;
            iload = rel_word_s;
        end else begin
            dwait = 1'b1;
            iwait = 1'b1;
        end
    end

    // Arbitration FSM with latched request and registered RAM strobes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            last_data_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            store_r     <= {DATA_W{1'b0}};
            ren_r       <= 1'b0;
            wen_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        state_r <= IGRANT;
                        addr_r  <= iaddr;
                        store_r <= {DATA_W{1'b0}};
                        ren_r   <= 1'b1;
                        wen_r   <= 1'b0;
                    end else if (grant_d_s) begin
                        state_r <= DGRANT;
                        addr_r  <= daddr;
                        store_r <= dstore;
                        ren_r   <= ~dWEN;
                        wen_r   <= dWEN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DGRANT, IGRANT: begin
                    if (release_s) begin
                        state_r     <= IDLE;
                        last_data_r <= (state_r == DGRANT);
                        ren_r       <= 1'b0;
                        wen_r       <= 1'b0;
                    end else if (!own_req_s) begin
                        state_r <= IDLE;
                        ren_r   <= 1'b0;
                        wen_r   <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ren_r   <= 1'b0;
                    wen_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Self-checking bench for ram_request_arbiter: vector table, scoreboard and corner sequences.
module tb_ram_request_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] dstore = '0, ramload = '0;
    logic [1:0]    ramstate = FREE;
    logic          iwait, dwait, ramREN, ramWEN, timeout_err;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;

    ram_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] load;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          is_data;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          busy;
        bit          exp_ren;
        bit          exp_wen;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare release against expectation; a release pops the scoreboard.
    task automatic observe(input string tag, input bit expect_rel);
        exp_t e;
        bit   rel;
        rel = (iwait === 1'b0) || (dwait === 1'b0);
        chk({tag, "_release"}, rel, expect_rel);
        if (rel) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_sb: release with empty scoreboard", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_dwait"}, dwait, !e.is_data);
                chk({tag, "_iwait"}, iwait, e.is_data);
                chk({tag, "_load"}, e.is_data ? dload : iload, e.load);
                chk({tag, "_otherload"}, e.is_data ? iload : dload, 32'h0);
            end
        end
    endtask

    task automatic drop_all();
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        ramstate = FREE;
    endtask

    task automatic idle_check(input string tag);
        @(negedge CLK);
        drop_all();
        ramload = $urandom;
        #1;
        chk({tag, "_idle_ren"}, ramREN, 1'b0);
        chk({tag, "_idle_wen"}, ramWEN, 1'b0);
        observe({tag, "_idle"}, 1'b0);
    endtask

    task automatic do_reset();
        drop_all();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_iwait"}, iwait, 1'b1);
        chk({tag, "_dwait"}, dwait, 1'b1);
        chk({tag, "_iload"}, iload, 32'h0);
        chk({tag, "_dload"}, dload, 32'h0);
        chk({tag, "_ramaddr"}, ramaddr, 32'h0);
        chk({tag, "_ramstore"}, ramstore, 32'h0);
        chk({tag, "_ramren"}, ramREN, 1'b0);
        chk({tag, "_ramwen"}, ramWEN, 1'b0);
        chk({tag, "_terr"}, timeout_err, 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge CLK);
        iREN = !v.is_data;
        dREN = v.is_data & v.rd;
        dWEN = v.is_data & v.wr;
        iaddr = v.is_data ? 32'h0BAD_0000 : v.addr;
        daddr = v.is_data ? v.addr : 32'h0BAD_1111;
        dstore = v.store;
        ramstate = FREE;
        sb.push_back('{v.is_data, v.load});
        for (int k = 0; k <= v.busy; k++) begin
            @(negedge CLK);
            ramstate = (k == v.busy) ? ACCESS : BUSY;
            ramload = (k == v.busy) ? v.load : $urandom;
            #1;
            chk({tag, "_ren"}, ramREN, v.exp_ren);
            chk({tag, "_wen"}, ramWEN, v.exp_wen);
            chk({tag, "_addr"}, ramaddr, v.addr);
            if (v.exp_wen) chk({tag, "_store"}, ramstore, v.store);
            observe(tag, k == v.busy);
            iaddr = $urandom;
            daddr = $urandom;
            dstore = $urandom;
        end
        idle_check(tag);
    endtask

    logic [1:0] hold_seq[4];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234, 2, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h80, 32'hCAFE, 32'h9999, 0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hBEEF_0001, 1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h84, 32'h55AA, 32'h0, 3, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1, 1'b1, 1'b0};
        hold_seq[0] = BUSY;
        hold_seq[1] = ERROR;
        hold_seq[2] = ERROR;
        hold_seq[3] = ACCESS;

        do_reset();
        #1;
        check_reset_vals("reset");

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Simultaneous requests from reset: data, instruction, then data again.
        do_reset();
        @(negedge CLK);
        iREN = 1'b1;
        dREN = 1'b1;
        iaddr = 32'h200;
        daddr = 32'h300;
        ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            ramload = 32'h11 * (k + 1);
            if (k == 0 || k == 4) sb.push_back('{1'b1, 32'h11 * (k + 1)});
            if (k == 2) sb.push_back('{1'b0, 32'h33});
            #1;
            if (k % 2 == 0) begin
                chk($sformatf("sim%0d_ren", k), ramREN, 1'b1);
                chk($sformatf("sim%0d_addr", k), ramaddr, (k == 2) ? 32'h200 : 32'h300);
            end else begin
                chk($sformatf("sim%0d_ren", k), ramREN, 1'b0);
            end
            observe($sformatf("sim%0d", k), k % 2 == 0);
        end
        idle_check("sim");

        // BUSY/ERROR hold, with address churn after the grant.
        @(negedge CLK);
        dREN = 1'b1;
        daddr = 32'h44;
        sb.push_back('{1'b1, 32'h77});
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            ramstate = hold_seq[k];
            ramload = (k == 3) ? 32'h77 : $urandom;
            #1;
            chk($sformatf("hold%0d_ren", k), ramREN, 1'b1);
            chk($sformatf("hold%0d_wen", k), ramWEN, 1'b0);
            chk($sformatf("hold%0d_addr", k), ramaddr, 32'h44);
            observe($sformatf("hold%0d", k), k == 3);
            daddr = $urandom;
        end
        idle_check("hold");

        // Instruction withdrawal while BUSY.
        @(negedge CLK);
        iREN = 1'b1;
        iaddr = 32'h500;
        ramstate = BUSY;
        @(negedge CLK);
        #1;
        chk("wd_ren_on", ramREN, 1'b1);
        chk("wd_addr", ramaddr, 32'h500);
        iREN = 1'b0;
        #1;
        observe("wd_drop", 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("wd%0d_ren", k), ramREN, 1'b0);
            observe($sformatf("wd%0d", k), 1'b0);
        end
        drop_all();

        // Reset pulse during DGRANT.
        @(negedge CLK);
        dREN = 1'b1;
        daddr = 32'h600;
        ramstate = BUSY;
        @(negedge CLK);
        #1;
        chk("rst_ren_pre", ramREN, 1'b1);
        #2;
        nRST = 1'b0;
        ramstate = ACCESS;
        #1;
        check_reset_vals("rst_mid");
        dREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("rst%0d_ren", k), ramREN, 1'b0);
            observe($sformatf("rst%0d", k), 1'b0);
        end
        drop_all();

`ifdef MEM_TIMEOUT_EN
        @(negedge CLK);
        dREN = 1'b1;
        daddr = 32'h60;
        ramstate = BUSY;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        for (int k = 0; k < TO; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("to%0d_ren", k), ramREN, 1'b1);
            observe($sformatf("to%0d", k), k == TO - 1);
        end
        @(negedge CLK);
        dREN = 1'b0;
        #1;
        chk("to_ren_after", ramREN, 1'b0);
        chk("to_err_set", timeout_err, 1'b1);
        repeat (5) @(negedge CLK);
        #1;
        chk("to_err_sticky", timeout_err, 1'b1);
        do_reset();
        #1;
        chk("to_err_cleared", timeout_err, 1'b0);
`else
        @(negedge CLK);
        dREN = 1'b1;
        daddr = 32'h60;
        ramstate = BUSY;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            #1;
            if (k % 5 == 4) chk($sformatf("nto%0d_ren", k), ramREN, 1'b1);
            observe($sformatf("nto%0d", k), 1'b0);
        end
        chk("nto_terr", timeout_err, 1'b0);
        drop_all();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
